// File: rtl/hwpe_stream_package.sv
// Shared TCDM widths and the round-robin winner search used by the HWPE stream arbiters.
package hwpe_stream_package;

  localparam int unsigned TCDM_ADDR_WIDTH = 32;
  localparam int unsigned TCDM_DATA_WIDTH = 32;
  localparam int unsigned TCDM_BE_WIDTH   = 4;
  localparam int unsigned RR_MAX_IN       = 16;

  // First set bit of req scanning ptr, ptr+1, ... modulo nb_in; returns ptr when req is empty.
  function automatic logic [3:0] rr_next(input logic [RR_MAX_IN-1:0] req,
                                         input logic [3:0]           ptr,
                                         input int unsigned          nb_in);
    logic [3:0] winner;
    logic       found;
    logic [4:0] idx;
    winner = ptr;
    found  = 1'b0;
    for (int unsigned i = 0; i < RR_MAX_IN; i++) begin
      if (i < nb_in) begin
        idx = {1'b0, ptr} + 5'(i);
        if (idx >= 5'(nb_in)) begin
          idx = idx - 5'(nb_in);
        end
        if (!found && req[idx[3:0]]) begin
          winner = idx[3:0];
          found  = 1'b1;
        end
      end
    end
    return winner;
  endfunction

endpackage

// File: rtl/hwpe_stream_tcdm_id_fifo.sv
// Circular FIFO of requester IDs for reads in flight; push when full and pop when empty are ignored.
module hwpe_stream_tcdm_id_fifo #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned WIDTH     = 2,
  parameter int unsigned CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 clear_i,
  input  logic                 push_i,
  input  logic [WIDTH-1:0]     data_i,
  input  logic                 pop_i,
  output logic [WIDTH-1:0]     head_o,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [PTR_WIDTH-1:0] r_wptr;
  logic [PTR_WIDTH-1:0] r_rptr;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 w_push;
  logic                 w_pop;

  assign full_o  = (r_count == CNT_WIDTH'(DEPTH));
  assign empty_o = (r_count == '0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign head_o  = r_mem[r_rptr];
  assign count_o = r_count;

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == PTR_WIDTH'(DEPTH - 1)) ? '0 : r_wptr + PTR_WIDTH'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PTR_WIDTH'(DEPTH - 1)) ? '0 : r_rptr + PTR_WIDTH'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_WIDTH'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_WIDTH'(1);
      end
    end
  end

  // Payload needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= data_i;
    end
  end

endmodule

// File: rtl/hwpe_stream_tcdm_rr_arbiter.sv
// Round-robin share of one TCDM port among NB_IN requesters; read responses are steered back
// in order through an ID FIFO.
module hwpe_stream_tcdm_rr_arbiter
  import hwpe_stream_package::*;
#(
  parameter int unsigned NB_IN         = 4,
  parameter int unsigned ID_FIFO_DEPTH = 4,
  parameter int unsigned ID_WIDTH      = $clog2(NB_IN),
  parameter int unsigned CNT_WIDTH     = $clog2(ID_FIFO_DEPTH + 1)
) (
  input  logic                               clk_i,
  input  logic                               clear_i,
  input  logic [NB_IN-1:0]                   in_req_i,
  output logic [NB_IN-1:0]                   in_gnt_o,
  input  logic [NB_IN*TCDM_ADDR_WIDTH-1:0]   in_add_i,
  input  logic [NB_IN-1:0]                   in_wen_i,
  input  logic [NB_IN*TCDM_BE_WIDTH-1:0]     in_be_i,
  input  logic [NB_IN*TCDM_DATA_WIDTH-1:0]   in_data_i,
  output logic [NB_IN*TCDM_DATA_WIDTH-1:0]   in_r_data_o,
  output logic [NB_IN-1:0]                   in_r_valid_o,
  output logic                               out_req_o,
  input  logic                               out_gnt_i,
  output logic [TCDM_ADDR_WIDTH-1:0]         out_add_o,
  output logic                               out_wen_o,
  output logic [TCDM_BE_WIDTH-1:0]           out_be_o,
  output logic [TCDM_DATA_WIDTH-1:0]         out_data_o,
  input  logic [TCDM_DATA_WIDTH-1:0]         out_r_data_i,
  input  logic                               out_r_valid_i,
  output logic [CNT_WIDTH-1:0]               outstanding_o,
  output logic                               err_o
);

  logic [ID_WIDTH-1:0]  r_ptr;
  logic [ID_WIDTH-1:0]  w_winner;
  logic [ID_WIDTH-1:0]  w_ptr_next;
  logic [ID_WIDTH-1:0]  w_head;
  logic [RR_MAX_IN-1:0] w_req_pad;
  logic                 w_any_req;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_hs;
  logic                 w_push;
  logic                 w_pop;
  logic                 r_err;

  always_comb begin
    w_req_pad              = '0;
    w_req_pad[NB_IN-1:0]   = in_req_i;
  end

  assign w_winner   = ID_WIDTH'(rr_next(w_req_pad, 4'(r_ptr), NB_IN));
  assign w_ptr_next = (w_winner == ID_WIDTH'(NB_IN - 1)) ? '0 : w_winner + ID_WIDTH'(1);
  assign w_any_req  = |in_req_i;

  // Full blocks requests even when a pop is due this cycle, so r_valid never feeds req.
  assign out_req_o  = w_any_req & ~w_full & ~clear_i;
  assign w_hs       = out_req_o & out_gnt_i;
  assign w_push     = w_hs & out_wen_o;
  assign w_pop      = out_r_valid_i & ~w_empty & ~clear_i;

  always_comb begin
    out_add_o  = '0;
    out_wen_o  = 1'b0;
    out_be_o   = '0;
    out_data_o = '0;
    in_gnt_o   = '0;
    for (int unsigned i = 0; i < NB_IN; i++) begin
      if (w_any_req && !clear_i && (w_winner == ID_WIDTH'(i))) begin
        out_add_o   = in_add_i[i*TCDM_ADDR_WIDTH +: TCDM_ADDR_WIDTH];
        out_wen_o   = in_wen_i[i];
        out_be_o    = in_be_i[i*TCDM_BE_WIDTH +: TCDM_BE_WIDTH];
        out_data_o  = in_data_i[i*TCDM_DATA_WIDTH +: TCDM_DATA_WIDTH];
        in_gnt_o[i] = w_hs;
      end
    end
  end

  always_comb begin
    in_r_valid_o = '0;
    for (int unsigned i = 0; i < NB_IN; i++) begin
      in_r_valid_o[i] = w_pop && (w_head == ID_WIDTH'(i));
    end
  end

  assign in_r_data_o = {NB_IN{out_r_data_i}};

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      r_ptr <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_hs) begin
        r_ptr <= w_ptr_next;
      end
      if (out_r_valid_i && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err_o = r_err;

  hwpe_stream_tcdm_id_fifo #(
    .DEPTH     (ID_FIFO_DEPTH),
    .WIDTH     (ID_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .clear_i (clear_i),
    .push_i  (w_push),
    .data_i  (w_winner),
    .pop_i   (w_pop),
    .head_o  (w_head),
    .count_o (outstanding_o),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

endmodule

// File: doc/hwpe_stream_tcdm_rr_arbiter.md
Name: hwpe_stream_tcdm_rr_arbiter

Overview:
- Shares one TCDM master port between NB_IN TCDM requesters, each of which is typically a streamer source or sink.
- Arbitration is round-robin. Read responses are routed back to the issuing requester in order, using an ID FIFO.
- Sits between the HWPE streamers and the cluster TCDM interconnect.
- Tolerates response latency of 1 or more cycles, e.g. when FIFOs are inserted downstream.

Parameters:
- NB_IN, 4: number of requester ports; range 2..16.
- ID_FIFO_DEPTH, 4: maximum outstanding reads; range 1..16.
- ID_WIDTH, $clog2(NB_IN): width of a requester index (derived).

Ports:
- clk_i  in  1  clock.
- clear_i  in  1  reset, synchronous, active-high.
- in_req_i  in  NB_IN  request per requester.
- in_gnt_o  out  NB_IN  grant per requester.
- in_add_i  in  NB_IN*32  address per requester.
- in_wen_i  in  NB_IN  1 = read, 0 = write.
- in_be_i  in  NB_IN*4  byte enables per requester.
- in_data_i  in  NB_IN*32  write data per requester.
- in_r_data_o  out  NB_IN*32  read data per requester.
- in_r_valid_o  out  NB_IN  read valid per requester.
- out_req_o  out  1  request to the shared TCDM port.
- out_gnt_i  in  1  grant from the shared port.
- out_add_o  out  32  address to the shared port.
- out_wen_o  out  1  read/write to the shared port.
- out_be_o  out  4  byte enables to the shared port.
- out_data_o  out  32  write data to the shared port.
- out_r_data_i  in  32  read data from the shared port.
- out_r_valid_i  in  1  read valid from the shared port.
- outstanding_o  out  $clog2(ID_FIFO_DEPTH+1)  number of reads in flight.
- err_o  out  1  sticky: r_valid received with the ID FIFO empty.

Behaviour:
- Reset: clk_i is the only clock. clear_i=1 at a clock edge sets:
  - ptr=0 and the ID FIFO empty;
  - outstanding_o=0 and err_o=0.
  - While reset holds, all combinational outputs read 0: out_req_o, in_gnt_o, in_r_valid_o, out_add/wen/be/data. in_r_data_o is a broadcast of out_r_data_i (see responses).
- Arbitration is combinational, zero cycles:
  - winner = first index i with in_req_i[i]=1, scanning ptr, ptr+1, … modulo NB_IN.
  - When no request is pending, out_add/wen/be/data = 0.
- full = (outstanding == ID_FIFO_DEPTH).
- out_req_o = |in_req_i & ~full. When full, new requests are blocked even if a pop occurs in the same cycle; this keeps the path free of a combinational r_valid->req loop.
- out_add/wen/be/data come from the winner.
- in_gnt_o[winner] = out_req_o & out_gnt_i. All other grant bits are 0.
- Handshake = out_req_o & out_gnt_i. On a handshake:
  - ptr <= (winner+1) mod NB_IN; otherwise ptr holds.
  - If out_wen_o=1 (read), the winner's ID is pushed into the ID FIFO.
  - Writes push nothing and receive no response.
- Responses:
  - When out_r_valid_i=1 and the FIFO is non-empty, the head ID is popped and in_r_valid_o[head]=1 in the same cycle.
  - in_r_data_o is out_r_data_i broadcast to every requester; only the valid bit is routed.
- Response with empty FIFO: out_r_valid_i=1 while the FIFO is empty is dropped. err_o <= 1 and stays set until clear_i.
- Simultaneous push and pop: outstanding stays unchanged. A 1-cycle-latency response to a grant at cycle t arrives at t+1 and pops correctly.
- Responses are strictly in order; out-of-order memories are unsupported.
- Reset mid-operation: IDs in flight are discarded. Their late r_valid is treated as an empty-FIFO response, setting err_o.
- Request inputs need not be stable across arbitration. Sources, however, must hold req until gnt (TCDM protocol).

Decomposition:
- The shared package hwpe_stream_package holds:
  - the localparam TCDM_ADDR_WIDTH=32, TCDM_DATA_WIDTH=32, TCDM_BE_WIDTH=4;
  - the function rr_next(req, ptr) returning the winner index.
- One sub-module: hwpe_stream_tcdm_id_fifo. It is a synchronous FIFO of ID_WIDTH-bit entries with push, pop, head, count, full and empty, plus the same clk_i/clear_i.

Test Plan:
- Single read, 1-cycle memory: NB_IN=4; req[2] with add=0x100 and wen=1. Expect:
  - cycle 0: gnt[2]=1 and outstanding goes to 1;
  - cycle 1: r_valid=1 with r_data=0xCAFE0100 delivered → in_r_valid_o=4'b0100 and outstanding=0.
- Round-robin fairness: all 4 requesters assert req continuously, out_gnt_i=1 → grant order is 0,1,2,3,0,1 with one grant per cycle.
- Backpressure: ID_FIFO_DEPTH=2, 3-cycle memory latency, requesters 0 and 1 issue reads. Expect:
  - 2 grants, then out_req_o=0 while full;
  - after the first r_valid, granting resumes;
  - responses reach 0 then 1, in order.
- Writes carry no response: interleave a write from requester 1 (add=0x40, be=4'b0011) with a read from requester 3. Expect:
  - outstanding peaks at 1;
  - the only r_valid is routed to index 3;
  - out_be_o equals 4'b0011 during the write grant.
- Spurious response: out_r_valid_i=1 with the FIFO empty → all in_r_valid_o=0 and err_o=1. err_o stays 1 until clear_i, after which it is 0.
- Clear mid-flight: issue 2 reads, pulse clear_i before the responses arrive. Expect outstanding_o=0 and ptr=0 after the clear; the next late r_valid sets err_o=1.
